// File: rtl/regs_banked.sv
// rtl/regs_banked.sv - ARM-style mode-banked register file with CPSR flags/mode and per-mode SPSRs
// Optional write-first read bypass on the in_reg port: define REGS_BYPASS_EN.
module regs_banked #(
  parameter int DATA_W  = 32,
  parameter int FLAGS_W = 4
) (
  input  logic               clock,
  input  logic               not_reset,
  input  logic               not_enable,
  input  logic [DATA_W-1:0]  in_reg,
  input  logic [3:0]         sel_in,
  input  logic [3:0]         sel_p0,
  input  logic [3:0]         sel_p1,
  input  logic [3:0]         sel_p2,
  output logic [DATA_W-1:0]  p0,
  output logic [DATA_W-1:0]  p1,
  output logic [DATA_W-1:0]  p2,
  input  logic [DATA_W-1:0]  pc_in,
  input  logic               flags_we,
  input  logic [FLAGS_W-1:0] in_flags,
  output logic [FLAGS_W-1:0] out_flags,
  input  logic               exc_enter,
  input  logic [1:0]         exc_new_mode,
  input  logic [DATA_W-1:0]  exc_lr,
  input  logic               exc_return,
  output logic [1:0]         mode
);

  localparam logic [1:0] MODE_USR = 2'd0;
  localparam logic [1:0] MODE_IRQ = 2'd1;
  localparam logic [1:0] MODE_SVC = 2'd2;
  localparam logic [1:0] MODE_FIQ = 2'd3;
  localparam int NPHYS  = 26;
  localparam int SPSR_W = FLAGS_W + 2;

  // Physical layout: 0-14 USR r0-r14, 15-21 FIQ r8-r14, 22-23 IRQ r13-r14, 24-25 SVC r13-r14.
  logic [DATA_W-1:0] rf   [0:NPHYS-1];
  logic [SPSR_W-1:0] spsr [0:3];

  function automatic logic [4:0] phys(input logic [3:0] sel, input logic [1:0] m);
    logic [4:0] s;
    s = {1'b0, sel};
    phys = s;
    case (m)
      MODE_FIQ: if (sel >= 4'd8)  phys = s + 5'd7;
      MODE_IRQ: if (sel >= 4'd13) phys = s + 5'd9;
      MODE_SVC: if (sel >= 4'd13) phys = s + 5'd11;
      default:  phys = s;
    endcase
  endfunction

  logic [4:0] wr_phys;
  logic [4:0] lr_phys;
  logic       wr_ok;
  logic       enter_ok;
  logic       return_ok;

  always_comb begin
    wr_phys   = phys(sel_in, mode);
    lr_phys   = phys(4'd14, exc_new_mode);
    wr_ok     = !not_enable && (sel_in != 4'd15);
    enter_ok  = exc_enter && (exc_new_mode != MODE_USR);
    return_ok = exc_return && (mode != MODE_USR) && !enter_ok;
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] sel);
    logic [4:0] ph;
    ph = phys(sel, mode);
    if (sel == 4'd15)
      read_port = pc_in;
`ifdef REGS_BYPASS_EN
    else if (wr_ok && ph == wr_phys)
      read_port = in_reg;
`endif
    else
      read_port = rf[ph];
  endfunction

  always_comb begin
    p0 = read_port(sel_p0);
    p1 = read_port(sel_p1);
    p2 = read_port(sel_p2);
  end

  always_ff @(posedge clock) begin
    if (!not_reset) begin
      for (int i = 0; i < NPHYS; i++) rf[i] <= '0;
      for (int i = 0; i < 4; i++) spsr[i] <= '0;
      out_flags <= '0;
      mode      <= MODE_SVC;
    end else if (!not_enable) begin
      if (wr_ok) rf[wr_phys] <= in_reg;
      // Entry is written after the ordinary write so exc_lr wins on a shared r14.
      if (enter_ok) begin
        rf[lr_phys]        <= exc_lr;
        spsr[exc_new_mode] <= {out_flags, mode};
        mode               <= exc_new_mode;
        if (flags_we) out_flags <= in_flags;
      end else if (return_ok) begin
        {out_flags, mode} <= spsr[mode];
      end else if (flags_we) begin
        out_flags <= in_flags;
      end
    end
  end

endmodule

// File: tb/tb_regs_banked.sv
// tb/tb_regs_banked.sv - scoreboard bench for regs_banked against a bank-level reference model
module tb_regs_banked;

  logic        clock = 1'b0;
  logic        not_reset, not_enable;
  logic [31:0] in_reg, pc_in, exc_lr;
  logic [3:0]  sel_in, sel_p0, sel_p1, sel_p2;
  logic [31:0] p0, p1, p2;
  logic        flags_we, exc_enter, exc_return;
  logic [3:0]  in_flags, out_flags;
  logic [1:0]  exc_new_mode, mode;

  regs_banked #(.DATA_W(32), .FLAGS_W(4)) dut (
    .clock(clock), .not_reset(not_reset), .not_enable(not_enable),
    .in_reg(in_reg), .sel_in(sel_in), .sel_p0(sel_p0), .sel_p1(sel_p1), .sel_p2(sel_p2),
    .p0(p0), .p1(p1), .p2(p2), .pc_in(pc_in), .flags_we(flags_we), .in_flags(in_flags),
    .out_flags(out_flags), .exc_enter(exc_enter), .exc_new_mode(exc_new_mode),
    .exc_lr(exc_lr), .exc_return(exc_return), .mode(mode)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [4:0]  mask;  // p0, p1, p2, flags, mode
    logic [31:0] p0, p1, p2;
    logic [3:0]  fl;
    logic [1:0]  md;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit done     = 0;

  // Reference model: one array per bank, holding only the registers that bank owns.
  logic [31:0] m_usr [0:14];
  logic [31:0] m_fiq [8:14];
  logic [31:0] m_irq [13:14];
  logic [31:0] m_svc [13:14];
  logic [5:0]  m_spsr [1:3];
  logic [3:0]  m_flags;
  logic [1:0]  m_mode;
  bit          m_valid = 0;

  function automatic logic [31:0] model_get(input logic [3:0] sel, input logic [1:0] md);
    if (md == 2'd3 && sel >= 8)       return m_fiq[sel];
    else if (md == 2'd1 && sel >= 13) return m_irq[sel];
    else if (md == 2'd2 && sel >= 13) return m_svc[sel];
    else                              return m_usr[sel];
  endfunction

  task automatic model_set(input logic [3:0] sel, input logic [1:0] md, input logic [31:0] v);
    if (md == 2'd3 && sel >= 8)       m_fiq[sel] = v;
    else if (md == 2'd1 && sel >= 13) m_irq[sel] = v;
    else if (md == 2'd2 && sel >= 13) m_svc[sel] = v;
    else                              m_usr[sel] = v;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] sel);
    if (sel == 4'd15) return pc_in;
`ifdef REGS_BYPASS_EN
    if (!not_enable && sel_in != 4'd15 && sel_in == sel) return in_reg;
`endif
    return model_get(sel, m_mode);
  endfunction

  task automatic model_edge();
    logic [3:0] f0;
    logic [1:0] md0;
    if (!not_reset) begin
      for (int i = 0; i < 15; i++) m_usr[i] = 0;
      for (int i = 8; i < 15; i++) m_fiq[i] = 0;
      for (int i = 13; i < 15; i++) begin m_irq[i] = 0; m_svc[i] = 0; end
      for (int i = 1; i < 4; i++) m_spsr[i] = 0;
      m_flags = 0;
      m_mode  = 2'd2;
      m_valid = 1;
    end else if (!not_enable) begin
      f0  = m_flags;
      md0 = m_mode;
      if (sel_in != 4'd15) model_set(sel_in, md0, in_reg);
      if (exc_enter && exc_new_mode != 2'd0) begin
        model_set(4'd14, exc_new_mode, exc_lr);
        m_spsr[exc_new_mode] = {f0, md0};
        m_mode  = exc_new_mode;
        m_flags = flags_we ? in_flags : f0;
      end else if (exc_return && md0 != 2'd0) begin
        {m_flags, m_mode} = m_spsr[md0];
      end else if (flags_we) begin
        m_flags = in_flags;
      end
    end
  endtask

  task automatic idle();
    not_reset = 1; not_enable = 0; sel_in = 4'd15; in_reg = $urandom;
    flags_we = 0; in_flags = 4'($urandom); exc_enter = 0; exc_return = 0;
    exc_new_mode = 2'd0; exc_lr = $urandom; pc_in = $urandom;
    sel_p0 = 4'd0; sel_p1 = 4'd1; sel_p2 = 4'd2;
  endtask

  task automatic expect_c(input string name, input logic [4:0] mask, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input logic [3:0] fl,
                          input logic [1:0] md);
    exp_t e;
    e.name = name; e.mask = mask; e.p0 = a; e.p1 = b; e.p2 = c; e.fl = fl; e.md = md;
    q.push_back(e);
  endtask

  task automatic cyc();
    if (m_valid)
      expect_c("model", 5'h1f, model_read(sel_p0), model_read(sel_p1), model_read(sel_p2),
               m_flags, m_mode);
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic cmp(input string name, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s actual=%h required=%h at %0t", name, fld, act, req, $time);
  endtask

  always @(negedge clock) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.mask[0]) cmp(e.name, "p0", p0, e.p0);
      if (e.mask[1]) cmp(e.name, "p1", p1, e.p1);
      if (e.mask[2]) cmp(e.name, "p2", p2, e.p2);
      if (e.mask[3]) cmp(e.name, "flags", {28'd0, out_flags}, {28'd0, e.fl});
      if (e.mask[4]) cmp(e.name, "mode", {30'd0, mode}, {30'd0, e.md});
    end
  end

  initial begin
    #2000000;
    if (!done) begin
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
    end
  end

  initial begin
    idle();
    @(posedge clock); #1;
    // 1: reset
    not_reset = 0; cyc();
    idle(); expect_c("reset", 5'h1f, 0, 0, 0, 4'h0, 2'd2); cyc();
    // 2: write r5 in SVC, sel_in=15 ignored
    idle(); sel_in = 5; in_reg = 32'h12345678; cyc();
    idle(); in_reg = 32'hFFFF; sel_p0 = 5; sel_p1 = 15; pc_in = 32'hCAFE0000;
    expect_c("wr_r5", 5'h03, 32'h12345678, 32'hCAFE0000, 0, 0, 0); cyc();
    // 3: not_enable blocks write and flags
    idle(); not_enable = 1; sel_in = 5; in_reg = 32'hDEAD; flags_we = 1; in_flags = 4'hC; cyc();
    idle(); sel_p0 = 5; expect_c("blocked", 5'h09, 32'h12345678, 0, 0, 4'h0, 0); cyc();
    idle(); sel_in = 5; in_reg = 32'hDEAD; cyc();
    idle(); sel_p0 = 5; expect_c("released", 5'h01, 32'hDEAD, 0, 0, 0, 0); cyc();
    // 4: banking
    idle(); sel_in = 13; in_reg = 32'hA0; cyc();
    idle(); exc_return = 1; cyc();
    idle(); sel_in = 13; in_reg = 32'hB0; expect_c("ret_usr", 5'h10, 0, 0, 0, 0, 2'd0); cyc();
    idle(); sel_in = 8; in_reg = 32'h8; cyc();
    idle(); exc_enter = 1; exc_new_mode = 2'd3; exc_lr = 32'h100; cyc();
    idle(); sel_p0 = 13; sel_p1 = 14; sel_p2 = 8;
    expect_c("fiq_bank", 5'h17, 0, 32'h100, 0, 0, 2'd3); cyc();
    idle(); exc_return = 1; cyc();
    idle(); sel_p0 = 13; sel_p2 = 8; expect_c("usr_bank", 5'h15, 32'hB0, 0, 32'h8, 0, 2'd0); cyc();
    // 5: flags with entry/return
    idle(); flags_we = 1; in_flags = 4'h9; cyc();
    idle(); exc_enter = 1; exc_new_mode = 2'd1; flags_we = 1; in_flags = 4'h4; cyc();
    idle(); exc_return = 1; expect_c("irq_in", 5'h18, 0, 0, 0, 4'h4, 2'd1); cyc();
    idle(); expect_c("irq_out", 5'h18, 0, 0, 0, 4'h9, 2'd0); cyc();
    // 6: same-cycle write/read and enter+return
    idle(); sel_in = 3; in_reg = 32'h55; sel_p1 = 3;
`ifdef REGS_BYPASS_EN
    expect_c("bypass", 5'h02, 0, 32'h55, 0, 0, 0);
`else
    expect_c("no_bypass", 5'h02, 0, 32'h0, 0, 0, 0);
`endif
    cyc();
    idle(); exc_enter = 1; exc_new_mode = 2'd1; exc_return = 1; cyc();
    idle(); expect_c("enter_wins", 5'h10, 0, 0, 0, 0, 2'd1); cyc();
    idle(); exc_enter = 1; exc_new_mode = 2'd2; sel_in = 14; in_reg = 32'h77; exc_lr = 32'h99; cyc();
    idle(); sel_p0 = 14; expect_c("lr_wins", 5'h11, 32'h99, 0, 0, 0, 2'd2); cyc();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      idle();
      not_reset    = ($urandom_range(0, 60) != 0);
      not_enable   = ($urandom_range(0, 3) == 0);
      sel_in       = 4'($urandom);
      flags_we     = ($urandom_range(0, 2) == 0);
      exc_enter    = ($urandom_range(0, 5) == 0);
      exc_new_mode = 2'($urandom);
      exc_return   = ($urandom_range(0, 5) == 0);
      sel_p0 = 4'($urandom); sel_p1 = 4'($urandom);
      sel_p2 = ($urandom_range(0, 1) == 0) ? sel_in : 4'($urandom);
      cyc();
    end
    idle();
    @(negedge clock); #1;
    if (q.size() != 0) cmp("drain", "queue", q.size(), 0);
    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
